// File: rtl/matrix_flit_packetiser_pkg.sv
// Shared flit format for the Hoplite matrix path: field widths, flit layout offsets and the
// injection-stage state type used by the packetiser.
package matrix_flit_packetiser_pkg;

  localparam int unsigned DEF_COORD_W = 4;
  localparam int unsigned DEF_IDX_W   = 4;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_FLIT_W  = 2*DEF_COORD_W + 2*DEF_IDX_W + DEF_DATA_W;

  // Flit layout, MSB first: {dst_x, dst_y, row, col, data}
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned COL_LSB  = DATA_LSB + DEF_DATA_W;
  localparam int unsigned ROW_LSB  = COL_LSB + DEF_IDX_W;
  localparam int unsigned Y_LSB    = ROW_LSB + DEF_IDX_W;
  localparam int unsigned X_LSB    = Y_LSB + DEF_COORD_W;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_t;

endpackage

// File: rtl/matrix_flit_packetiser_sync_fifo.sv
// Single-clock FIFO with registered full/empty. A push while full is accepted when a pop
// frees the head slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/matrix_flit_packetiser.sv
// Tags out_matrix element writes with {dest, row, col}, buffers them and injects them one flit
// at a time into the local Hoplite router port; pulses matrix_sent once a matrix has fully left.
module matrix_flit_packetiser
  import matrix_flit_packetiser_pkg::*;
#(
  parameter int unsigned COORD_W    = DEF_COORD_W,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_W-1:0]                    in_elem,
  input  logic                                 in_elem_en,
  input  logic                                 in_end_row,
  input  logic                                 in_end,
  input  logic [2*COORD_W-1:0]                 in_position,
  input  logic                                 in_position_en,
  output logic [2*COORD_W+2*IDX_W+DATA_W-1:0]  flit_out,
  output logic                                 flit_out_valid,
  input  logic                                 flit_out_ready,
  output logic                                 fifo_full,
  output logic                                 overflow,
  output logic                                 matrix_sent
);

  localparam int unsigned FW = 2*COORD_W + 2*IDX_W + DATA_W;

  out_state_t           state;
  logic [2*COORD_W-1:0] dest;
  logic [IDX_W-1:0]     row;
  logic [IDX_W-1:0]     col;
  logic                 end_pending;
  logic [FW-1:0]        push_data;
  logic [FW-1:0]        head;
  logic                 fifo_empty;
  logic                 pop;
  logic                 slot_free;

  assign push_data = {dest, row, col, in_elem};

  // The output register can take a new flit when it is empty or its flit is accepted now.
  assign slot_free   = (state == OUT_IDLE) || flit_out_ready;
  assign pop         = !fifo_empty && slot_free;
  assign matrix_sent = end_pending && fifo_empty && slot_free;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_elem_en),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dest        <= '0;
      row         <= '0;
      col         <= '0;
      end_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (in_position_en)
        dest <= in_position;

      if (in_end) begin
        row <= '0;
        col <= '0;
      end else if (in_end_row) begin
        row <= row + IDX_W'(1);
        col <= '0;
      end else if (in_elem_en) begin
        col <= col + IDX_W'(1);
      end

      if (in_elem_en && fifo_full && !pop)
        overflow <= 1'b1;

      if (in_end)
        end_pending <= 1'b1;
      else if (matrix_sent)
        end_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= OUT_IDLE;
      flit_out       <= '0;
      flit_out_valid <= 1'b0;
    end else begin
      case (state)
        OUT_IDLE: begin
          if (pop) begin
            flit_out       <= head;
            flit_out_valid <= 1'b1;
            state          <= OUT_HOLD;
          end
        end
        OUT_HOLD: begin
          if (flit_out_ready) begin
            if (pop) begin
              flit_out <= head;
            end else begin
              flit_out_valid <= 1'b0;
              state          <= OUT_IDLE;
            end
          end
        end
        default: begin
          flit_out_valid <= 1'b0;
          state          <= OUT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_flit_packetiser.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_matrix_flit_packetiser;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_elem = '0;
  logic        in_elem_en = 1'b0;
  logic        in_end_row = 1'b0;
  logic        in_end = 1'b0;
  logic [7:0]  in_position = '0;
  logic        in_position_en = 1'b0;
  logic [23:0] flit_out;
  logic        flit_out_valid;
  logic        flit_out_ready = 1'b0;
  logic        fifo_full;
  logic        overflow;
  logic        matrix_sent;

  always #5 clk = ~clk;

  matrix_flit_packetiser #(
    .COORD_W    (4),
    .IDX_W      (4),
    .DATA_W     (8),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_elem        (in_elem),
    .in_elem_en     (in_elem_en),
    .in_end_row     (in_end_row),
    .in_end         (in_end),
    .in_position    (in_position),
    .in_position_en (in_position_en),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .flit_out_ready (flit_out_ready),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .matrix_sent    (matrix_sent)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Reference model: buffered flits, the one flit on the wire, and the tagging state.
  logic [23:0] m_q[$];
  logic        m_valid = 1'b0;
  logic [23:0] m_flit = '0;
  logic        m_over = 1'b0;
  logic [7:0]  m_dest = '0;
  logic [3:0]  m_row = '0;
  logic [3:0]  m_col = '0;
  logic        m_endp = 1'b0;

  logic [23:0] acc[$];
  int unsigned sent_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic er, input logic e,
                      input logic pe, input logic [7:0] p, input logic rdy, input logic rst);
    int   sz;
    logic room;
    logic pop;
    logic [23:0] nf;
    @(negedge clk);
    check("valid", 32'(flit_out_valid), 32'(m_valid));
    check("flit", 32'(flit_out), 32'(m_flit));
    check("full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_over));
    in_elem_en = en; in_elem = d; in_end_row = er; in_end = e;
    in_position_en = pe; in_position = p; flit_out_ready = rdy; reset = rst;
    #1;
    sz   = m_q.size();
    room = !m_valid || rdy;
    check("sent", 32'(matrix_sent), 32'(m_endp && sz == 0 && room));
    if (flit_out_valid && rdy && !rst) acc.push_back(flit_out);
    if (matrix_sent && !rst) sent_cnt++;
    if (rst) begin
      m_q.delete(); m_valid = 0; m_flit = '0; m_over = 0;
      m_dest = '0; m_row = '0; m_col = '0; m_endp = 0;
    end else begin
      pop = (sz > 0) && room;
      nf  = {m_dest, m_row, m_col, d};
      if (m_endp && sz == 0 && room) m_endp = 0;
      if (e) m_endp = 1;
      if (pop) begin
        m_flit = m_q.pop_front();
        m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      if (en) begin
        if (sz < DEPTH || pop) m_q.push_back(nf);
        else m_over = 1;
      end
      if (e) begin m_row = '0; m_col = '0; end
      else if (er) begin m_row = m_row + 4'd1; m_col = '0; end
      else if (en) m_col = m_col + 4'd1;
      if (pe) m_dest = p;
    end
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 8'h00, rdy, 0);
  endtask

  task automatic do_reset();
    step(0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    acc.delete();
    sent_cnt = 0;
  endtask

  int unsigned n_before;
  logic [23:0] f_before;
  logic [2:0]  rseq [5];

  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    #5;
    check("rst_valid", 32'(flit_out_valid), 32'h0);
    check("rst_flit", 32'(flit_out), 32'h0);
    check("rst_full", 32'(fifo_full), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_sent", 32'(matrix_sent), 32'h0);

    // Two rows then end, router always ready
    step(0, 8'h00, 0, 0, 1, 8'h21, 1, 0);
    step(1, 8'h0A, 0, 0, 0, 8'h00, 1, 0);
    step(1, 8'h0B, 0, 0, 0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    step(1, 8'h0C, 0, 0, 0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1, 0, 8'h00, 1, 0);
    idle(6, 1);
    check("t1_count", acc.size(), 3);
    check("t1_flit0", 32'(acc[0]), 32'h21000A);
    check("t1_flit1", 32'(acc[1]), 32'h21010B);
    check("t1_flit2", 32'(acc[2]), 32'h21100C);
    check("t1_sent_pulses", sent_cnt, 1);

    // Fill while stalled: one flit sits on the output, 16 in the FIFO, the 18th is dropped
    do_reset();
    for (int unsigned i = 0; i < 18; i++) step(1, 8'(i), 0, 0, 0, 8'h00, 0, 0);
    #5;
    check("t2_full", 32'(fifo_full), 32'h1);
    check("t2_overflow", 32'(overflow), 32'h1);
    idle(22, 1);
    check("t2_count", acc.size(), 17);
    for (int unsigned i = 0; i < acc.size(); i++) begin
      check("t2_data", 32'(acc[i][7:0]), i);
      check("t2_col", 32'(acc[i][11:8]), i % 16);
    end
    check("t2_overflow_sticky", 32'(overflow), 32'h1);

    // Hold stability under a toggling ready
    do_reset();
    for (int unsigned i = 0; i < 4; i++) step(1, 8'h40 + 8'(i), 0, 0, 0, 8'h00, 0, 0);
    idle(2, 0);
    rseq = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1};
    n_before = acc.size();
    for (int unsigned k = 0; k < 5; k++) begin
      f_before = flit_out;
      step(0, 8'h00, 0, 0, 0, 8'h00, rseq[k][0], 0);
      #5;
      if (rseq[k][0] == 1'b0) check("t3_hold_stable", 32'(flit_out), 32'(f_before));
    end
    check("t3_accepted", acc.size() - n_before, 2);
    idle(6, 1);

    // Element, end_row and position load in the same cycle
    do_reset();
    step(0, 8'h00, 0, 0, 1, 8'h10, 1, 0);
    step(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    for (int unsigned i = 0; i < 5; i++) step(1, 8'h00, 0, 0, 0, 8'h00, 1, 0);
    step(1, 8'h55, 1, 0, 1, 8'h33, 1, 0);
    step(1, 8'h66, 0, 0, 0, 8'h00, 1, 0);
    idle(5, 1);
    check("t4_count", acc.size(), 7);
    check("t4_combined", 32'(acc[5]), 32'h102555);
    check("t4_next", 32'(acc[6]), 32'h333066);

    // End with nothing buffered
    do_reset();
    idle(2, 0);
    step(0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    check("t5_sent_next", 32'(matrix_sent), 32'h1);
    step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    check("t5_sent_once", 32'(matrix_sent), 32'h0);
    check("t5_no_valid", 32'(flit_out_valid), 32'h0);

    // Reset while holding a flit with more queued
    do_reset();
    for (int unsigned i = 0; i < 5; i++) step(1, 8'h70 + 8'(i), 0, 0, 0, 8'h00, 0, 0);
    idle(2, 0);
    check("t6_holding", 32'(flit_out_valid), 32'h1);
    do_reset();
    #5;
    check("t6_valid", 32'(flit_out_valid), 32'h0);
    check("t6_full", 32'(fifo_full), 32'h0);
    check("t6_overflow", 32'(overflow), 32'h0);
    idle(6, 1);
    check("t6_no_flits", acc.size(), 0);

    // Random traffic
    do_reset();
    for (int unsigned i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 55,
           8'($urandom),
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 5,
           8'($urandom),
           $urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 70 : 25),
           $urandom_range(0, 999) < 4);
    end
    idle(25, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
